// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bundle of the NUM_IN ingress AXIS streams and the merged egress AXIS stream around the arbiter.
// master: arbiter view (drives egress and per-input ready); slave: surrounding sources/sink view.
interface axis_pkt_rr_arbiter_if #(
  parameter int unsigned DWIDTH = 512,
  parameter int unsigned NUM_IN = 4
);
  localparam int unsigned KEEP_WIDTH = DWIDTH / 8;
  localparam int unsigned SEL_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]            in_tvalid;
  logic [NUM_IN-1:0]            in_tready;
  logic [NUM_IN*DWIDTH-1:0]     in_tdata;
  logic [NUM_IN*KEEP_WIDTH-1:0] in_tkeep;
  logic [NUM_IN-1:0]            in_tlast;
  logic [NUM_IN-1:0]            in_tuser;

  logic                         axis_tvalid;
  logic                         axis_tready;
  logic [DWIDTH-1:0]            axis_tdata;
  logic [KEEP_WIDTH-1:0]        axis_tkeep;
  logic                         axis_tlast;
  logic                         axis_tuser;
  logic [SEL_W-1:0]             axis_tid;

  modport master (
    input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser, axis_tready,
    output in_tready, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser, axis_tid
  );

  modport slave (
    output in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser, axis_tready,
    input  in_tready, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser, axis_tid
  );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN AXIS streams into one registered AXIS output.
// A grant is held from the first beat of a packet through its tlast beat; one IDLE cycle re-arbitrates.
module axis_pkt_rr_arbiter #(
  parameter int unsigned DWIDTH = 512,
  parameter int unsigned NUM_IN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_pkt_rr_arbiter_if.master bus
);
  localparam int unsigned KEEP_WIDTH = DWIDTH / 8;
  localparam int unsigned SEL_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [SEL_W-1:0]      grant, grant_nxt;
  logic [SEL_W-1:0]      last_grant, last_grant_nxt;
  logic [SEL_W-1:0]      arb_idx, cand;
  logic                  arb_found;

  logic                  load_en;
  logic                  accept;
  logic [NUM_IN-1:0]     in_tready_c;

  logic [DWIDTH-1:0]     sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic                  sel_tlast;
  logic                  sel_tuser;

  logic                  tvalid_q;
  logic [DWIDTH-1:0]     tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tlast_q;
  logic                  tuser_q;
  logic [SEL_W-1:0]      tid_q;

  // Output slot is free when empty or being drained this cycle.
  assign load_en = bus.axis_tready | ~tvalid_q;

  // Ready only to the granted input; never a function of its own tvalid.
  assign in_tready_c = (state == PASS && load_en) ? (NUM_IN'(1) << grant) : '0;
  assign accept      = |(bus.in_tvalid & in_tready_c);

  // Payload mux of the granted input.
  always_comb begin
    sel_tdata = '0;
    sel_tkeep = '0;
    sel_tlast = 1'b0;
    sel_tuser = 1'b0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grant == SEL_W'(i)) begin
        sel_tdata = bus.in_tdata[i*DWIDTH +: DWIDTH];
        sel_tkeep = bus.in_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tlast = bus.in_tlast[i];
        sel_tuser = bus.in_tuser[i];
      end
    end
  end

  // Cyclic search for the first requester after last_grant.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(NUM_IN); k++) begin
      cand = SEL_W'((int'(last_grant) + k) % int'(NUM_IN));
      if (!arb_found && bus.in_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nxt = arb_idx;
          state_nxt = PASS;
        end
      end
      PASS: begin
        if (accept && sel_tlast) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Egress register; payload only reloads on an accepted beat so a stall holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tid_q    <= '0;
    end else if (load_en) begin
      tvalid_q <= accept;
      if (accept) begin
        tdata_q <= sel_tdata;
        tkeep_q <= sel_tkeep;
        tlast_q <= sel_tlast;
        tuser_q <= sel_tuser;
        tid_q   <= grant;
      end
    end
  end

  assign bus.in_tready   = in_tready_c;
  assign bus.axis_tvalid = tvalid_q;
  assign bus.axis_tdata  = tdata_q;
  assign bus.axis_tkeep  = tkeep_q;
  assign bus.axis_tlast  = tlast_q;
  assign bus.axis_tuser  = tuser_q;
  assign bus.axis_tid    = tid_q;
endmodule
